hex_cmd_parser: RTL and testbench
=================================

// Module: hex_cmd_parser
// PURPOSE
//  Byte-stream parser for UART calculator commands "I <type><src1><op><src2>=". Sits between the UART RX byte stream and the ALU.
//  Successor to the fixed 4/4-digit parser, adding:
//   - parametrised operand width; 1..DIGITS hex digits per operand, either case;
//   - eight operators; valid/ready output handshake with input backpressure;
//   - error reporting; optional inactivity timeout.
// PARAMETERS
//  DIGITS   4  max hex digits per operand; operand width W = 4*DIGITS (localparam)
//  TIMEOUT  0  idle cycles mid-command before abort; 0 = disabled
// PORTS
//  clk       in   1   clock; single clock domain
//  rst       in   1   synchronous reset, active-high
//  in_data   in   8   ASCII byte from UART RX
//  in_valid  in   1   in_data valid; byte consumed when in_valid & in_ready
//  in_ready  out  1   parser can accept a byte
//  out_valid out  1   parsed command available
//  out_ready in   1   ALU accepts command
//  dtype     out  4   1 = unsigned ('U'/'u'), 2 = signed ('S'/'s')
//  op        out  8   one-hot: + 01, - 02, * 04, / 08, % 10, & 20, | 40, ^ 80
//  src1      out  W   operand 1, zero-extended
//  src2      out  W   operand 2, zero-extended
//  err       out  1   one-cycle pulse: command aborted
//  err_code  out  3   1 FMT, 2 OVF (too many digits), 3 EMPTY (no digits), 4 TMO; held until next err
// BEHAVIOUR
//  Reset: state IDLE; out_valid, err, err_code, dtype, op, src1, src2 all 0; digit and timeout counters 0.
//   rst wins over every other event. Reset mid-command discards the partial command; outputs return to 0.
//  in_ready = (state != DONE).
//  FSM, advancing on each accepted byte:
//   IDLE: 'I' (0x49) -> SEP; any other byte is discarded silently.
//   SEP:  ' ' (0x20) -> TYPE; other -> FMT.
//   TYPE: S/s/U/u -> latch type, clear shift regs and digit count -> SRC1; other -> FMT.
//   SRC1 hex digit:
//    - count < DIGITS: shift in at LSB (acc <= {acc[W-5:0], nib}), count++;
//    - count == DIGITS: OVF.
//   SRC1 operator (+ - * / % & | ^ = 2B 2D 2A 2F 25 26 7C 5E):
//    - count > 0: latch op, clear count -> SRC2;
//    - count == 0: EMPTY.
//   SRC1 other -> FMT.
//   SRC2 hex digit: same rule as SRC1.
//   SRC2 '=' (0x3D):
//    - count > 0: -> DONE;
//    - count == 0: EMPTY.
//   SRC2 other -> FMT.
//   DONE: out_valid = 1, no bytes accepted; out_ready -> IDLE next cycle.
//  Output registers:
//   - dtype/op/src1/src2 load only on the cycle that enters DONE;
//   - registered, so out_valid rises 1 cycle after the '=' is accepted;
//   - stable while out_valid=1 and until the next DONE.
//  Errors:
//   - the offending byte is consumed;
//   - err pulses 1 cycle, err_code is set, FSM -> IDLE;
//   - output registers are not disturbed.
//  Timeout (TIMEOUT > 0):
//   - counter runs in SEP/TYPE/SRC1/SRC2; cleared on every accepted byte and in IDLE/DONE;
//   - reaching TIMEOUT aborts with TMO;
//   - a byte accepted in the same cycle takes precedence (no timeout that cycle).
//  DONE with out_ready and in_valid in the same cycle: the byte is not accepted (in_ready=0); IDLE next cycle.
//  Hex digits: 0-9 (30-39), a-f (61-66), A-F (41-46).
// STRUCTURE
//  Shared header hex_cmd_defs.vh: state encodings, ASCII constants, op one-hot codes, dtype codes, err codes.
//  Sub-module ascii_hex_decode (combinational): byte -> is_hex, nib[3:0], is_op, op_oh[7:0].
//   Reused by the result formatter.
// TESTING
//  1 DIGITS=4: "I S12ab+00FF=" -> out_valid=1, dtype=2, op=01, src1=12ab, src2=00ff.
//  2 "I u7*A=" -> src1=0007, src2=000a, op=04, dtype=1 (short operands zero-extended).
//  3 "I U12345" -> err=1, code=2 on the 5th digit; FSM idle; next "I U1-1=" parses with op=02.
//  4 Backpressure:
//     - complete a command, hold out_ready=0 for 10 cycles -> out_valid and outputs stable, in_ready=0,
//       a driven byte is ignored;
//     - raise out_ready -> next cycle out_valid=0, in_ready=1.
//  5 TIMEOUT=16:
//     - "I S1" then idle -> err code 4 exactly 16 cycles after the last accepted byte;
//     - a byte arriving on cycle 16 instead continues parsing.
//  6 Error and reset cases:
//     - "I S+5=" -> code 3; "I X" -> code 1;
//     - rst mid "I S12" -> all outputs 0, then "I S0^f=" -> op=80, src2=000f.

Source files
------------

// File: rtl/hex_cmd_parser_pkg.sv
// Shared encodings for the UART calculator command parser:
// FSM states, ASCII markers, operator one-hots, type and error codes.
package hex_cmd_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEP  = 3'd1,
    ST_TYPE = 3'd2,
    ST_SRC1 = 3'd3,
    ST_SRC2 = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_EQ = 8'h3D;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h04;
  localparam logic [7:0] OP_DIV = 8'h08;
  localparam logic [7:0] OP_MOD = 8'h10;
  localparam logic [7:0] OP_AND = 8'h20;
  localparam logic [7:0] OP_OR  = 8'h40;
  localparam logic [7:0] OP_XOR = 8'h80;

  localparam logic [3:0] DT_NONE = 4'd0;
  localparam logic [3:0] DT_U    = 4'd1;
  localparam logic [3:0] DT_S    = 4'd2;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_FMT   = 3'd1;
  localparam logic [2:0] ERR_OVF   = 3'd2;
  localparam logic [2:0] ERR_EMPTY = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;

  // Type letter to dtype code; DT_NONE when not S/s/U/u.
  function automatic logic [3:0] type_code(input logic [7:0] c);
    logic [3:0] t;
    case (c)
      8'h53, 8'h73: t = DT_S;
      8'h55, 8'h75: t = DT_U;
      default:      t = DT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII classifier: hex digit value and
// operator one-hot. Shared with the result formatter.
module ascii_hex_decode
  import hex_cmd_parser_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_hex,
  output logic [3:0] nib,
  output logic       is_op,
  output logic [7:0] op_oh
);

  // Hex digit recognition, either letter case
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    unique case (1'b1)
      (data >= 8'h30) && (data <= 8'h39): begin
        is_hex = 1'b1;
        nib    = data[3:0];
      end
      (data >= 8'h41) && (data <= 8'h46),
      (data >= 8'h61) && (data <= 8'h66): begin
        is_hex = 1'b1;
        nib    = data[3:0] + 4'd9;
      end
      default: ;
    endcase
  end

  // Operator character to one-hot code
  always_comb begin
    op_oh = 8'd0;
    case (data)
      8'h2B:   op_oh = OP_ADD;
      8'h2D:   op_oh = OP_SUB;
      8'h2A:   op_oh = OP_MUL;
      8'h2F:   op_oh = OP_DIV;
      8'h25:   op_oh = OP_MOD;
      8'h26:   op_oh = OP_AND;
      8'h7C:   op_oh = OP_OR;
      8'h5E:   op_oh = OP_XOR;
      default: op_oh = 8'd0;
    endcase
  end

  assign is_op = |op_oh;

endmodule

// File: rtl/hex_cmd_parser.sv
// Byte-stream parser for "I <type><src1><op><src2>=" commands
// feeding the ALU through a valid/ready handshake.
module hex_cmd_parser
  import hex_cmd_parser_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          dtype,
  output logic [7:0]          op,
  output logic [4*DIGITS-1:0] src1,
  output logic [4*DIGITS-1:0] src2,
  output logic                err,
  output logic [2:0]          err_code
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc1_q, acc1_d;
  logic [W-1:0]   acc2_q, acc2_d;
  logic [3:0]     typ_q, typ_d;
  logic [7:0]     opl_q, opl_d;
  logic [TW-1:0]  tmo_q;

  logic       accept;
  logic       is_hex;
  logic [3:0] nib;
  logic       is_op;
  logic [7:0] op_oh;
  logic [3:0] tcode;
  logic       is_eq;
  logic       digits_full;
  logic       has_digits;
  logic       tmo_run;
  logic       tmo_hit;
  logic       abort;
  logic [2:0] abort_code;
  logic       enter_done;

  ascii_hex_decode u_dec (
    .data   (in_data),
    .is_hex (is_hex),
    .nib    (nib),
    .is_op  (is_op),
    .op_oh  (op_oh)
  );

  assign in_ready    = (state_q != ST_DONE);
  assign out_valid   = (state_q == ST_DONE);
  assign accept      = in_valid && in_ready;
  assign tcode       = type_code(in_data);
  assign is_eq       = (in_data == CH_EQ);
  assign digits_full = (cnt_q == CW'(DIGITS));
  assign has_digits  = (cnt_q != '0);
  assign enter_done  = (state_d == ST_DONE) && (state_q != ST_DONE);

  assign tmo_run = (state_q == ST_SEP)  || (state_q == ST_TYPE) ||
                   (state_q == ST_SRC1) || (state_q == ST_SRC2);
  assign tmo_hit = (TIMEOUT > 0) && tmo_run && !accept &&
                   (tmo_q == TW'(TIMEOUT - 1));

  // Next-state, operand accumulation and abort detection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc1_d     = acc1_q;
    acc2_d     = acc2_q;
    typ_d      = typ_q;
    opl_d      = opl_q;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_data == CH_I) state_d = ST_SEP;
        end
        ST_SEP: begin
          if (in_data == CH_SP) begin
            state_d = ST_TYPE;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_FMT;
          end
        end
        ST_TYPE: begin
          if (tcode != DT_NONE) begin
            typ_d   = tcode;
            acc1_d  = '0;
            acc2_d  = '0;
            cnt_d   = '0;
            state_d = ST_SRC1;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_FMT;
          end
        end
        ST_SRC1: begin
          unique case (1'b1)
            is_hex && digits_full: begin
              abort      = 1'b1;
              abort_code = ERR_OVF;
            end
            is_hex && !digits_full: begin
              acc1_d = (acc1_q << 4) | W'(nib);
              cnt_d  = cnt_q + CW'(1);
            end
            is_op && has_digits: begin
              opl_d   = op_oh;
              cnt_d   = '0;
              state_d = ST_SRC2;
            end
            is_op && !has_digits: begin
              abort      = 1'b1;
              abort_code = ERR_EMPTY;
            end
            default: begin
              abort      = 1'b1;
              abort_code = ERR_FMT;
            end
          endcase
        end
        ST_SRC2: begin
          unique case (1'b1)
            is_hex && digits_full: begin
              abort      = 1'b1;
              abort_code = ERR_OVF;
            end
            is_hex && !digits_full: begin
              acc2_d = (acc2_q << 4) | W'(nib);
              cnt_d  = cnt_q + CW'(1);
            end
            is_eq && has_digits: begin
              state_d = ST_DONE;
            end
            is_eq && !has_digits: begin
              abort      = 1'b1;
              abort_code = ERR_EMPTY;
            end
            default: begin
              abort      = 1'b1;
              abort_code = ERR_FMT;
            end
          endcase
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_DONE) begin
      if (out_ready) state_d = ST_IDLE;
    end else if (tmo_hit) begin
      abort      = 1'b1;
      abort_code = ERR_TMO;
    end
    if (abort) state_d = ST_IDLE;
  end

  // FSM state and parse accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      typ_q   <= DT_NONE;
      opl_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      typ_q   <= typ_d;
      opl_q   <= opl_d;
    end
  end

  // Idle cycles spent mid-command, cleared by any accepted byte
  always_ff @(posedge clk) begin
    if (rst || !tmo_run || accept || tmo_hit || (TIMEOUT == 0)) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // Command outputs load on DONE entry; error pulse and sticky code
  always_ff @(posedge clk) begin
    if (rst) begin
      dtype    <= DT_NONE;
      op       <= 8'd0;
      src1     <= '0;
      src2     <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      err <= abort;
      if (abort) err_code <= abort_code;
      if (enter_done) begin
        dtype <= typ_q;
        op    <= opl_q;
        src1  <= acc1_q;
        src2  <= acc2_q;
      end
    end
  end

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Self-checking bench: string-level reference parser, per-cycle
// compare, directed command cases and randomized byte streams.
module tb_hex_cmd_parser;

  localparam int DIGITS = 4;
  localparam int TMO    = 16;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   dtype;
  logic [7:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         err;
  logic [2:0]   err_code;

  always #5 clk = ~clk;

  hex_cmd_parser #(.DIGITS(DIGITS), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dtype     (dtype),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .err       (err),
    .err_code  (err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic         m_valid;
  logic         m_err;
  logic [2:0]   m_code;
  logic [3:0]   m_dt;
  logic [7:0]   m_op;
  logic [W-1:0] m_s1;
  logic [W-1:0] m_s2;
  bit           m_act;
  int           m_idle;
  bit           m_live = 1'b0;
  logic [7:0]   m_buf[$];

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic int opidx(input logic [7:0] c);
    case (c)
      8'h2B:   return 0;
      8'h2D:   return 1;
      8'h2A:   return 2;
      8'h2F:   return 3;
      8'h25:   return 4;
      8'h26:   return 5;
      8'h7C:   return 6;
      8'h5E:   return 7;
      default: return -1;
    endcase
  endfunction

  // Judge a whole command text: kind 0 incomplete, 1 error, 2 complete.
  function automatic void judge(input logic [7:0] b[$], output int kind,
      output logic [2:0] code, output logic [3:0] dt, output logic [7:0] o,
      output logic [W-1:0] s1, output logic [W-1:0] s2);
    int n;
    int i;
    int nd;
    n = b.size();
    kind = 0; code = 0; dt = 0; o = 0; s1 = 0; s2 = 0;
    if (n < 2) return;
    if (b[1] != 8'h20) begin kind = 1; code = 1; return; end
    if (n < 3) return;
    if (b[2] == 8'h53 || b[2] == 8'h73) dt = 2;
    else if (b[2] == 8'h55 || b[2] == 8'h75) dt = 1;
    else begin kind = 1; code = 1; return; end
    i = 3; nd = 0;
    while (i < n && hexval(b[i]) >= 0) begin
      if (nd == DIGITS) begin kind = 1; code = 2; return; end
      s1 = (s1 << 4) | W'(hexval(b[i]));
      nd++; i++;
    end
    if (i == n) return;
    if (opidx(b[i]) < 0) begin kind = 1; code = 1; return; end
    if (nd == 0) begin kind = 1; code = 3; return; end
    o = 8'd1 << opidx(b[i]);
    i++; nd = 0;
    while (i < n && hexval(b[i]) >= 0) begin
      if (nd == DIGITS) begin kind = 1; code = 2; return; end
      s2 = (s2 << 4) | W'(hexval(b[i]));
      nd++; i++;
    end
    if (i == n) return;
    if (b[i] != 8'h3D) begin kind = 1; code = 1; return; end
    if (nd == 0) begin kind = 1; code = 3; return; end
    kind = 2;
  endfunction

  task automatic model_step();
    int kind;
    logic [2:0] code;
    logic [3:0] dt;
    logic [7:0] o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    m_err = 1'b0;
    if (rst) begin
      m_valid = 0; m_code = 0; m_dt = 0; m_op = 0; m_s1 = 0; m_s2 = 0;
      m_act = 0; m_idle = 0; m_buf.delete();
      return;
    end
    if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
      return;
    end
    if (in_valid) begin
      m_idle = 0;
      if (!m_act) begin
        if (in_data == 8'h49) begin
          m_act = 1'b1;
          m_buf.delete();
          m_buf.push_back(in_data);
        end
        return;
      end
      m_buf.push_back(in_data);
      judge(m_buf, kind, code, dt, o, a, b);
      if (kind == 1) begin
        m_err = 1'b1; m_code = code; m_act = 1'b0;
      end else if (kind == 2) begin
        m_valid = 1'b1; m_act = 1'b0;
        m_dt = dt; m_op = o; m_s1 = a; m_s2 = b;
      end
      return;
    end
    if (m_act) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_err = 1'b1; m_code = 3'd4; m_act = 1'b0; m_idle = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    m_live = 1'b1;
  end

  // Per-cycle compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("in_ready",  32'(in_ready),  32'(!m_valid));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("err",       32'(err),       32'(m_err));
      chk("err_code",  32'(err_code),  32'(m_code));
      chk("dtype",     32'(dtype),     32'(m_dt));
      chk("op",        32'(op),        32'(m_op));
      chk("src1",      32'(src1),      32'(m_s1));
      chk("src2",      32'(src2),      32'(m_s2));
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_stall got in_ready=0 want 1 byte %0h", b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  function automatic logic [7:0] hexch(input int v);
    if (v < 10) return 8'(48 + v);
    if ($urandom_range(0, 1) == 1) return 8'(65 + v - 10);
    return 8'(97 + v - 10);
  endfunction

  function automatic logic [7:0] opch(input int k);
    case (k)
      0:       return 8'h2B;
      1:       return 8'h2D;
      2:       return 8'h2A;
      3:       return 8'h2F;
      4:       return 8'h25;
      5:       return 8'h26;
      6:       return 8'h7C;
      default: return 8'h5E;
    endcase
  endfunction

  function automatic logic [7:0] typech(input int k);
    case (k)
      0:       return 8'h53;
      1:       return 8'h73;
      2:       return 8'h55;
      default: return 8'h75;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int n1;
    int n2;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_err_code",  32'(err_code),  32'd0);
    chk("rst_src1",      32'(src1),      32'd0);

    send_str("I S12ab+00FF=");
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_dtype", 32'(dtype), 32'd2);
    chk("t1_op",    32'(op),    32'h01);
    chk("t1_src1",  32'(src1),  32'h12ab);
    chk("t1_src2",  32'(src2),  32'h00ff);
    tick();

    send_str("I u7*A=");
    chk("t2_dtype", 32'(dtype), 32'd1);
    chk("t2_op",    32'(op),    32'h04);
    chk("t2_src1",  32'(src1),  32'h0007);
    chk("t2_src2",  32'(src2),  32'h000a);
    tick();

    send_str("I U1234");
    send(8'h35);
    chk("t3_err",  32'(err),      32'd1);
    chk("t3_code", 32'(err_code), 32'd2);
    send_str("I U1-1=");
    chk("t3_op",   32'(op),   32'h02);
    chk("t3_src1", 32'(src1), 32'h1);
    tick();

    out_ready = 1'b0;
    send_str("I S9/3=");
    in_data  = 8'h49;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready),  32'd0);
      chk("bp_src1",  32'(src1),      32'h9);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_ready", 32'(in_ready),  32'd1);
    tick();

    send_str("I S1");
    repeat (15) tick();
    chk("tmo_early", 32'(err), 32'd0);
    tick();
    chk("tmo_err",  32'(err),      32'd1);
    chk("tmo_code", 32'(err_code), 32'd4);
    send_str("I S1");
    repeat (15) tick();
    send(8'h2B);
    chk("tmo_save", 32'(err), 32'd0);
    send_str("2=");
    chk("tmo_valid", 32'(out_valid), 32'd1);
    chk("tmo_src2",  32'(src2),      32'h2);
    tick();

    send_str("I S+");
    chk("empty_err",  32'(err),      32'd1);
    chk("empty_code", 32'(err_code), 32'd3);
    send_str("5=");
    send_str("I X");
    chk("fmt_err",  32'(err),      32'd1);
    chk("fmt_code", 32'(err_code), 32'd1);

    send_str("I S12");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_op",    32'(op),        32'd0);
    chk("mrst_src1",  32'(src1),      32'd0);
    chk("mrst_code",  32'(err_code),  32'd0);
    send_str("I S0^f=");
    chk("t6_op",   32'(op),   32'h80);
    chk("t6_src2", 32'(src2), 32'h000f);
    tick();

    rnd_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      q.delete();
      q.push_back(8'h49);
      q.push_back(8'h20);
      q.push_back(typech($urandom_range(0, 3)));
      n1 = ($urandom_range(0, 3) != 0) ? $urandom_range(1, DIGITS)
                                       : $urandom_range(0, DIGITS + 1);
      for (int j = 0; j < n1; j++) q.push_back(hexch($urandom_range(0, 15)));
      q.push_back(opch($urandom_range(0, 7)));
      n2 = ($urandom_range(0, 3) != 0) ? $urandom_range(1, DIGITS)
                                       : $urandom_range(0, DIGITS + 1);
      for (int j = 0; j < n2; j++) q.push_back(hexch($urandom_range(0, 15)));
      q.push_back(8'h3D);
      if ($urandom_range(0, 7) == 0)
        q[$urandom_range(0, q.size() - 1)] = 8'($urandom_range(32, 126));
      foreach (q[j]) begin
        send(q[j]);
        if ($urandom_range(0, 15) == 0) repeat ($urandom_range(0, 20)) tick();
        else if ($urandom_range(0, 3) == 0) tick();
      end
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(32, 126)));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
